fix_engine_core: RTL and testbench
==================================

# fix_engine_core

FIX-protocol session engine between the application API and the TCP offload engine (TOE). It sequences a connection request, waits for the TOE connect acknowledge, streams a fixed FIX Logon message into the outbound FIFO, parses inbound bytes for message completion, and streams a Logout before releasing the connection. Everything is in one clock domain, and there is no backpressure on the outbound byte stream.

## Interface
- No parameters. Message contents and widths are fixed.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- connect_i  in  1  level from app: 1 = hold session open, 0 = close.
- connect_to_host_i  in  2  host id requested by app; sampled when connect_i is seen high in IDLE.
- connected_i  in  1  TOE connection-established indication.
- connected_host_addr_i  in  2  host id qualifying connected_i.
- message_i  in  8  inbound byte from TOE.
- valid_i  in  1  message_i qualifier.
- new_message_i  in  1  pulse: next valid byte starts a new inbound message; clears the parser.
- connect_req_o  out  1  one-cycle connect request to FIFO.
- disconnect_o  out  1  one-cycle disconnect request to FIFO.
- connect_addr_o  out  2  latched host id; valid with connect_req_o and held afterwards.
- disconnect_host_num_o  out  2  host id being released; valid with disconnect_o.
- send_message_valid_o  out  1  outbound byte qualifier.
- message_o  out  8  outbound byte (registered).
- message_received_o  out  1  one-cycle pulse per complete inbound message.

## Operation
- FSM states: IDLE, REQ, WAIT_CONN, LOGON, SESSION, LOGOUT, DISC.
- IDLE:
  - If connect_i=1, latch host = connect_to_host_i and go to REQ.
- REQ:
  - Drive connect_req_o=1 and connect_addr_o=host for exactly one cycle, then go to WAIT_CONN.
- WAIT_CONN:
  - If connected_i=1 and connected_host_addr_i==host, go to LOGON.
  - connected_i with a different address is ignored.
  - If connect_i=0, go to DISC. DISC takes precedence if both conditions occur in the same cycle.
- LOGON:
  - Emit the 15-byte Logon string, one byte per cycle, with send_message_valid_o=1: "8=FIX.4.2"<SOH>"35=A"<SOH>.
  - SOH = 8'h01. Bytes in order: 38 3D 46 49 58 2E 34 2E 32 01 33 35 3D 41 01.
  - After the last byte, go to SESSION.
  - connect_i dropping mid-stream does not truncate the message; it is evaluated in SESSION.
- SESSION:
  - If connect_i=0, go to LOGOUT.
- LOGOUT:
  - Emit the 15-byte Logout string, identical to Logon except byte 14 = "5" (8'h35), then go to DISC.
- DISC:
  - Drive disconnect_o=1 and disconnect_host_num_o=host for one cycle, then return to IDLE.
- Inbound parser:
  - Active in SESSION, LOGOUT and DISC; inbound bytes in all other states are discarded.
  - Only bytes with valid_i=1 are considered.
  - Matcher states: START, then after SOH (or message start) "1" → "0" → "=", then checksum digits until SOH.
  - On the SOH that terminates the tag-10 field, message_received_o pulses on the next cycle and the parser returns to START.
  - A mismatch returns the matcher to waiting for SOH.
  - new_message_i=1 forces the START state in that cycle; it overrides any byte accepted in the same cycle.

## Timing
- Reset values:
  - All outputs 0; message_o=8'h00.
  - FSM in IDLE; host latch 0; parser in START.
- connect_i high sampled at edge N: connect_req_o is high during cycle N+1 only.
- connected_i accepted at edge M: first Logon byte appears at cycle M+1. Bytes are on consecutive cycles M+1..M+15; send_message_valid_o is high exactly 15 cycles.
- connect_i low sampled in SESSION at edge K:
  - Logout bytes occupy cycles K+1..K+15.
  - disconnect_o pulses at cycle K+16.
  - IDLE at K+17; a new connect request is possible from K+17.
- Abort from WAIT_CONN: disconnect_o is high in the cycle after connect_i=0 is sampled.
- message_received_o: one cycle after the accepted terminating SOH. Back-to-back messages each produce their own pulse.
- Asserting reset mid-stream immediately clears all outputs, with no partial-message completion.

## Test plan
- Reset: rst=0 → all outputs 0. rst=1, idle 5 cycles → still all 0.
- Connect host 0:
  - connect_i=1, connect_to_host_i=0 → connect_req_o pulses one cycle with connect_addr_o=0.
  - Then connected_i=1 with connected_host_addr_i=0 → 15 consecutive bytes 38 3D … 41 01 with send_message_valid_o.
- Wrong host:
  - Request host 2; connected_i with addr 1 → no output.
  - Then connected_i with addr 2 → Logon stream starts the following cycle.
- Inbound parse:
  - In SESSION, feed "8=FIX.4.2|35=0|10=123|" (with SOH as the separator) under valid_i → exactly one message_received_o pulse, one cycle after the final SOH.
  - A second message immediately after → a second pulse.
- Disconnect:
  - In SESSION, connect_i=0 → Logout stream (byte 14 = 8'h35).
  - Then disconnect_o with disconnect_host_num_o=host one cycle after byte 15, then IDLE.
- Abort/reset:
  - connect_i=0 in WAIT_CONN → immediate disconnect_o.
  - rst=0 during Logon byte 7 → outputs 0 at once and no further bytes after release.

Source files
------------

// File: rtl/fix_engine_core.sv
// FIX session engine: connect handshake, fixed Logon/Logout streaming toward the TOE,
// and inbound scanning for the tag-10 checksum field that closes each message.
module fix_engine_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       connect_i,
  input  logic [1:0] connect_to_host_i,
  input  logic       connected_i,
  input  logic [1:0] connected_host_addr_i,
  input  logic [7:0] message_i,
  input  logic       valid_i,
  input  logic       new_message_i,
  output logic       connect_req_o,
  output logic       disconnect_o,
  output logic [1:0] connect_addr_o,
  output logic [1:0] disconnect_host_num_o,
  output logic       send_message_valid_o,
  output logic [7:0] message_o,
  output logic       message_received_o
);

  localparam int unsigned MSG_LEN = 15;
  localparam int unsigned IDX_W   = 4;
  localparam logic [7:0]  SOH     = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_CONN, S_LOGON, S_SESSION, S_LOGOUT, S_DISC
  } state_t;

  typedef enum logic [2:0] {
    P_START, P_WAIT_SOH, P_GOT_1, P_GOT_10, P_CKSUM
  } pstate_t;

  state_t             state_q, state_d;
  pstate_t            pstate_q, pstate_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         host_q, host_d;
  logic               connect_req_d, disconnect_d, send_valid_d, msg_rcvd_d;
  logic [1:0]         disc_host_d;
  logic [7:0]         message_d;
  logic               parser_active;
  logic               last_byte;

  // Logon and Logout differ only in the MsgType value (byte 14).
  function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx, input logic logout);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h38;
      4'd1:    b = 8'h3D;
      4'd2:    b = 8'h46;
      4'd3:    b = 8'h49;
      4'd4:    b = 8'h58;
      4'd5:    b = 8'h2E;
      4'd6:    b = 8'h34;
      4'd7:    b = 8'h2E;
      4'd8:    b = 8'h32;
      4'd9:    b = SOH;
      4'd10:   b = 8'h33;
      4'd11:   b = 8'h35;
      4'd12:   b = 8'h3D;
      4'd13:   b = logout ? 8'h35 : 8'h41;
      4'd14:   b = SOH;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign last_byte      = (idx_q == IDX_W'(MSG_LEN - 1));
  assign connect_addr_o = host_q;

  // Session FSM; outputs are computed from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    host_d  = host_q;
    case (state_q)
      S_IDLE: begin
        if (connect_i) begin
          host_d  = connect_to_host_i;
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT_CONN;
      S_WAIT_CONN: begin
        if (!connect_i) begin
          state_d = S_DISC;
        end else if (connected_i && (connected_host_addr_i == host_q)) begin
          state_d = S_LOGON;
          idx_d   = '0;
        end
      end
      S_LOGON: begin
        if (last_byte) state_d = S_SESSION;
        else           idx_d   = IDX_W'(idx_q + 4'd1);
      end
      S_SESSION: begin
        if (!connect_i) begin
          state_d = S_LOGOUT;
          idx_d   = '0;
        end
      end
      S_LOGOUT: begin
        if (last_byte) state_d = S_DISC;
        else           idx_d   = IDX_W'(idx_q + 4'd1);
      end
      S_DISC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    connect_req_d = (state_d == S_REQ);
    disconnect_d  = (state_d == S_DISC);
    disc_host_d   = disconnect_d ? host_q : 2'b00;
    send_valid_d  = (state_d == S_LOGON) || (state_d == S_LOGOUT);
    message_d     = send_valid_d ? msg_byte(idx_d, state_d == S_LOGOUT) : 8'h00;
  end

  assign parser_active = (state_q == S_SESSION) || (state_q == S_LOGOUT) || (state_q == S_DISC);

  // Inbound matcher: looks for a field starting "10=" and ending on SOH.
  always_comb begin
    pstate_d   = pstate_q;
    msg_rcvd_d = 1'b0;
    if (new_message_i || !parser_active) begin
      pstate_d = P_START;
    end else if (valid_i) begin
      if (message_i == SOH) begin
        pstate_d   = P_START;
        msg_rcvd_d = (pstate_q == P_CKSUM);
      end else begin
        case (pstate_q)
          P_START:  pstate_d = (message_i == 8'h31) ? P_GOT_1  : P_WAIT_SOH;
          P_GOT_1:  pstate_d = (message_i == 8'h30) ? P_GOT_10 : P_WAIT_SOH;
          P_GOT_10: pstate_d = (message_i == 8'h3D) ? P_CKSUM  : P_WAIT_SOH;
          P_CKSUM:  pstate_d = ((message_i >= 8'h30) && (message_i <= 8'h39)) ? P_CKSUM : P_WAIT_SOH;
          default:  pstate_d = P_WAIT_SOH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q               <= S_IDLE;
      pstate_q              <= P_START;
      idx_q                 <= '0;
      host_q                <= '0;
      connect_req_o         <= 1'b0;
      disconnect_o          <= 1'b0;
      disconnect_host_num_o <= 2'b00;
      send_message_valid_o  <= 1'b0;
      message_o             <= 8'h00;
      message_received_o    <= 1'b0;
    end else begin
      state_q               <= state_d;
      pstate_q              <= pstate_d;
      idx_q                 <= idx_d;
      host_q                <= host_d;
      connect_req_o         <= connect_req_d;
      disconnect_o          <= disconnect_d;
      disconnect_host_num_o <= disc_host_d;
      send_message_valid_o  <= send_valid_d;
      message_o             <= message_d;
      message_received_o    <= msg_rcvd_d;
    end
  end

endmodule

// File: tb/tb_fix_engine_core.sv
// Directed session sequence plus randomized inbound traffic for fix_engine_core,
// checked against a field-string model of FIX message completion.
module tb_fix_engine_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       connect_i;
  logic [1:0] connect_to_host_i;
  logic       connected_i;
  logic [1:0] connected_host_addr_i;
  logic [7:0] message_i;
  logic       valid_i;
  logic       new_message_i;
  logic       connect_req_o;
  logic       disconnect_o;
  logic [1:0] connect_addr_o;
  logic [1:0] disconnect_host_num_o;
  logic       send_message_valid_o;
  logic [7:0] message_o;
  logic       message_received_o;

  int errors = 0;
  int checks = 0;
  int rx_seen = 0;

  logic [7:0] logon_b  [15];
  logic [7:0] logout_b [15];
  logic [7:0] alpha    [8] = '{8'h31, 8'h30, 8'h3D, 8'h32, 8'h39, 8'h41, 8'h01, 8'h38};

  // Reference parser: bytes of the current field since the last SOH / message start.
  logic [7:0] field[$];
  bit         model_active = 1'b0;

  fix_engine_core dut (
    .clk                   (clk),
    .rst                   (rst),
    .connect_i             (connect_i),
    .connect_to_host_i     (connect_to_host_i),
    .connected_i           (connected_i),
    .connected_host_addr_i (connected_host_addr_i),
    .message_i             (message_i),
    .valid_i               (valid_i),
    .new_message_i         (new_message_i),
    .connect_req_o         (connect_req_o),
    .disconnect_o          (disconnect_o),
    .connect_addr_o        (connect_addr_o),
    .disconnect_host_num_o (disconnect_host_num_o),
    .send_message_valid_o  (send_message_valid_o),
    .message_o             (message_o),
    .message_received_o    (message_received_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"},   32'(connect_req_o),         32'd0);
    chk({tag, "_disc"},  32'(disconnect_o),          32'd0);
    chk({tag, "_dhost"}, 32'(disconnect_host_num_o), 32'd0);
    chk({tag, "_valid"}, 32'(send_message_valid_o),  32'd0);
    chk({tag, "_msg"},   32'(message_o),             32'd0);
    chk({tag, "_rx"},    32'(message_received_o),    32'd0);
  endtask

  function automatic bit field_is_cksum();
    if (field.size() < 3) return 1'b0;
    if (field[0] != 8'h31 || field[1] != 8'h30 || field[2] != 8'h3D) return 1'b0;
    for (int i = 3; i < field.size(); i++)
      if (field[i] < 8'h30 || field[i] > 8'h39) return 1'b0;
    return 1'b1;
  endfunction

  task automatic feed(input logic [7:0] b, input bit v, input bit nm, input string tag);
    bit exp;
    exp = model_active && v && !nm && (b == 8'h01) && field_is_cksum();
    if (nm || !model_active) field.delete();
    else if (v) begin
      if (b == 8'h01) field.delete();
      else            field.push_back(b);
    end
    message_i     = b;
    valid_i       = v;
    new_message_i = nm;
    tick();
    if (message_received_o === 1'b1) rx_seen++;
    chk(tag, 32'(message_received_o), 32'(exp));
  endtask

  task automatic feed_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      c = 8'(s[i]);
      if (c == 8'h23) c = 8'h01;
      feed(c, 1'b1, 1'b0, tag);
    end
    valid_i = 1'b0;
  endtask

  // Checks a 15-byte outbound stream, optionally dropping connect_i partway through.
  task automatic check_stream(input bit logout, input int drop_at, input string tag);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == drop_at) connect_i = 1'b0;
      chk({tag, "_valid"}, 32'(send_message_valid_o), 32'd1);
      chk({tag, "_byte"},  32'(message_o), 32'(logout ? logout_b[i] : logon_b[i]));
    end
  endtask

  initial begin
    logic [1:0] h;
    int         vcount;
    string      lg, lo;
    lg = "8=FIX.4.2#35=A#";
    lo = "8=FIX.4.2#35=5#";
    for (int i = 0; i < 15; i++) begin
      logon_b[i]  = (8'(lg[i]) == 8'h23) ? 8'h01 : 8'(lg[i]);
      logout_b[i] = (8'(lo[i]) == 8'h23) ? 8'h01 : 8'(lo[i]);
    end

    rst = 1'b1; connect_i = 1'b0; connect_to_host_i = 2'd0; connected_i = 1'b0;
    connected_host_addr_i = 2'd0; message_i = 8'h00; valid_i = 1'b0; new_message_i = 1'b0;
    #2 rst = 1'b0;
    repeat (2) tick();
    chk_quiet("reset");
    chk("reset_addr", 32'(connect_addr_o), 32'd0);
    rst = 1'b1;
    repeat (5) tick();
    chk_quiet("idle5");

    // Connect to host 0
    connect_i = 1'b1; connect_to_host_i = 2'd0;
    tick();
    chk("req0_pulse", 32'(connect_req_o), 32'd1);
    chk("req0_addr",  32'(connect_addr_o), 32'd0);
    connect_to_host_i = 2'd3;
    tick();
    chk("req0_end",  32'(connect_req_o), 32'd0);
    chk("req0_hold", 32'(connect_addr_o), 32'd0);
    repeat (3) tick();
    chk("wait0_valid", 32'(send_message_valid_o), 32'd0);
    connected_i = 1'b1; connected_host_addr_i = 2'd0;
    check_stream(1'b0, -1, "logon0");
    connected_i = 1'b0;
    tick();
    chk("session0_valid", 32'(send_message_valid_o), 32'd0);

    // Inbound parsing in SESSION
    model_active = 1'b1; field.delete(); rx_seen = 0;
    feed_str("8=FIX.4.2#35=0#10=123#", "rx_msg1");
    feed_str("8=FIX.4.2#35=0#10=045#", "rx_msg2");
    chk("rx_two_pulses", 32'(rx_seen), 32'd2);
    feed_str("10=9", "rx_nm_pre");
    feed(8'h01, 1'b1, 1'b1, "rx_nm_override");
    feed_str("10=7#", "rx_after_nm");
    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0) feed_str("10=42#", "rx_rnd_ck");
      else feed(alpha[$urandom_range(0, 7)], ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 24) == 0), "rx_rnd");
    end
    valid_i = 1'b0; new_message_i = 1'b0;

    // Logout and release of host 0
    connect_i = 1'b0;
    check_stream(1'b1, -1, "logout0");
    tick();
    chk("disc0_pulse", 32'(disconnect_o), 32'd1);
    chk("disc0_host",  32'(disconnect_host_num_o), 32'd0);
    chk("disc0_valid", 32'(send_message_valid_o), 32'd0);
    tick();
    chk("disc0_end", 32'(disconnect_o), 32'd0);
    model_active = 1'b0;

    // Immediate reconnect to host 2; wrong-host acknowledge ignored
    connect_i = 1'b1; connect_to_host_i = 2'd2;
    tick();
    chk("req2_pulse", 32'(connect_req_o), 32'd1);
    chk("req2_addr",  32'(connect_addr_o), 32'd2);
    tick();
    chk("req2_end",  32'(connect_req_o), 32'd0);
    chk("req2_hold", 32'(connect_addr_o), 32'd2);
    connected_i = 1'b1; connected_host_addr_i = 2'd1;
    vcount = 0;
    repeat (3) begin
      tick();
      if (send_message_valid_o !== 1'b0 || connect_req_o !== 1'b0) vcount++;
    end
    chk("wrong_host_silent", 32'(vcount), 32'd0);
    connected_host_addr_i = 2'd2;
    check_stream(1'b0, 5, "logon2");
    connected_i = 1'b0;
    tick();
    chk("session2_valid", 32'(send_message_valid_o), 32'd0);
    check_stream(1'b1, -1, "logout2");
    tick();
    chk("disc2_pulse", 32'(disconnect_o), 32'd1);
    chk("disc2_host",  32'(disconnect_host_num_o), 32'd2);
    tick();
    chk("disc2_end", 32'(disconnect_o), 32'd0);

    // Parser ignores traffic while idle
    model_active = 1'b0;
    feed_str("10=55#", "rx_idle");

    // Abort from WAIT_CONN; close wins over a simultaneous matching acknowledge
    h = 2'($urandom_range(0, 3));
    connect_i = 1'b1; connect_to_host_i = h;
    tick();
    chk("reqh_addr", 32'(connect_addr_o), 32'(h));
    tick();
    connect_i = 1'b0; connected_i = 1'b1; connected_host_addr_i = h;
    tick();
    chk("abort_disc",  32'(disconnect_o), 32'd1);
    chk("abort_host",  32'(disconnect_host_num_o), 32'(h));
    chk("abort_valid", 32'(send_message_valid_o), 32'd0);
    connected_i = 1'b0;
    tick();
    chk("abort_end",   32'(disconnect_o), 32'd0);
    chk("abort_valid2", 32'(send_message_valid_o), 32'd0);

    // Reset during Logon byte 7
    connect_i = 1'b1; connect_to_host_i = 2'd1;
    tick(); tick();
    connected_i = 1'b1; connected_host_addr_i = 2'd1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("rst_logon_byte", 32'(message_o), 32'(logon_b[i]));
    end
    connected_i = 1'b0; connect_i = 1'b0;
    rst = 1'b0;
    #1;
    chk_quiet("rst_mid");
    chk("rst_mid_addr", 32'(connect_addr_o), 32'd0);
    tick(); tick();
    rst = 1'b1;
    vcount = 0;
    repeat (20) begin
      tick();
      if (send_message_valid_o !== 1'b0 || message_received_o !== 1'b0 ||
          disconnect_o !== 1'b0 || message_o !== 8'h00) vcount++;
    end
    chk("post_rst_silent", 32'(vcount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
